game_binary_quiz_n: RTL and testbench
=====================================

GAME_BINARY_QUIZ_N -- requirements
Module: game_binary_quiz_n

Interface
REQ-001 SHALL have parameter NUM_BITS, default 3, meaning bits per target number, legal range 2..4.
REQ-002 SHALL have parameter ROUNDS, default 5, meaning rounds per game, legal range 1..9.
REQ-003 SHALL have parameter DELAY_TIME, default 10_000_000, meaning cycles per bit/result/score display.
REQ-004 SHALL have parameter GAP_TIME, default 2_000_000, meaning cycles of blank display after each bit.
REQ-005 SHALL have parameter QUIZ_TIMEOUT, default 50_000_000, meaning answer window in cycles.
REQ-006 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value, nonzero.
REQ-007 SHALL have port clk, input, 1 bit, meaning clock, all state updated on rising edge.
REQ-008 SHALL have port reset, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-009 SHALL have port btn, input, 2^NUM_BITS-1 bits, meaning btn[i] pressed = answer i+1.
REQ-010 SHALL have port value, output reg, 4 bits, meaning display code: 0/1 bit, 0..9 score, 10 correct, 11 error, 12 blank, 13 '?'.
REQ-011 SHALL have port score, output reg, 4 bits, meaning correct answers in current game.
REQ-012 SHALL have port dbg_target, output, NUM_BITS bits, meaning current target, for verification only.

Function
REQ-013 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle including IDLE.
REQ-014 SHALL detect presses on rising edges only: press = btn & ~btn_q, with btn_q registered each cycle; the lowest-index press wins.
REQ-015 SHALL load each new target from LFSR[NUM_BITS-1:0], with 0 replaced by 2^NUM_BITS-1.
REQ-016 SHALL implement states IDLE, SHOW_BIT, GAP, QUIZ, RESULT and SCORE; value SHALL take the new state's code on the same edge that enters the state.
REQ-017 IDLE: value=12; any press -> load target, bit_idx=NUM_BITS-1, round=0, score=0, enter SHOW_BIT.
REQ-018 SHOW_BIT: value=target[bit_idx] (MSB first) for exactly DELAY_TIME cycles, then GAP.
REQ-019 GAP: value=12 for exactly GAP_TIME cycles; if bit_idx>0, decrement it and re-enter SHOW_BIT; otherwise enter QUIZ.
REQ-020 QUIZ: value=13; a press with answer==target -> RESULT with value=10 and score+1 (saturating at 9); any other press -> RESULT with value=11.
REQ-021 RESULT: hold for exactly DELAY_TIME cycles; if round+1<ROUNDS, increment round, load a new target and enter SHOW_BIT; otherwise enter SCORE.
REQ-022 SCORE: value=score for exactly DELAY_TIME cycles, then IDLE; the score port keeps its value until the next game starts.
REQ-023 SHALL ignore presses in SHOW_BIT, GAP, RESULT and SCORE.
REQ-024 Because presses are edge-detected, a button held from IDLE into QUIZ SHALL NOT count as an answer.
REQ-025 SHALL size the delay counter to $clog2 of the maximum of DELAY_TIME, GAP_TIME and QUIZ_TIMEOUT, clearing it to 0 on every state change.
REQ-026 Unreachable state codes SHALL return to IDLE on the next edge, with value=12.

Reset
REQ-027 Reset SHALL set state=IDLE, value=12, score=0, round=0, counter=0, btn_q=0, LFSR=SEED and target=2^NUM_BITS-1, effective immediately, including mid-game.
REQ-028 After reset is released, the first press SHALL be detected only on a rising edge of btn.

Configuration
REQ-029 Macro BINARY_QUIZ_TIMEOUT_EN defined: if no press occurs within QUIZ_TIMEOUT cycles in QUIZ, the block SHALL enter RESULT with value=11; a press in the expiry cycle wins over the timeout.
REQ-030 Macro BINARY_QUIZ_TIMEOUT_EN undefined: QUIZ SHALL wait indefinitely, and the QUIZ_TIMEOUT parameter SHALL be unused.

Verification (NUM_BITS=3, ROUNDS=2, DELAY_TIME=4, GAP_TIME=2, QUIZ_TIMEOUT=8, macro defined)
REQ-031 Reset, then press btn[0]; dbg_target=5 -> value sequence 1x4, 12x2, 0x4, 12x2, 1x4, 12x2, then 13.
REQ-032 In QUIZ with dbg_target=5, press btn[4] -> value=10 for 4 cycles, score=1, second round starts with a new target.
REQ-033 In QUIZ with dbg_target=5, press btn[2] and btn[4] in the same cycle -> answer=3, value=11, score unchanged.
REQ-034 In QUIZ, give no press for 8 cycles -> value=11; after round 2, value=score for 4 cycles, then 12.
REQ-035 Hold btn[4] high from IDLE through the whole bit sequence -> value stays 13 in QUIZ and no RESULT occurs until btn falls and rises again (or the timeout expires).
REQ-036 Assert reset during GAP of round 2 -> value=12 and score=0 immediately, and the next press restarts at round 0.

Source files
------------

// File: rtl/game_binary_quiz_n.sv
// Binary quiz game: shows a random NUM_BITS-bit target MSB first, then waits for the answer button.
// Latency: each bit/result/score shown DELAY_TIME cycles, GAP_TIME blank after each bit; answer registered on the press edge.
// Backpressure: none; presses outside QUIZ are dropped. Define BINARY_QUIZ_TIMEOUT_EN to bound the answer window.
module game_binary_quiz_n #(
  parameter int          NUM_BITS     = 3,
  parameter int          ROUNDS       = 5,
  parameter int          DELAY_TIME   = 10_000_000,
  parameter int          GAP_TIME     = 2_000_000,
  parameter int          QUIZ_TIMEOUT = 50_000_000,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [(1<<NUM_BITS)-2:0] btn,
  output logic [3:0]               value,
  output logic [3:0]               score,
  output logic [NUM_BITS-1:0]      dbg_target
);

  localparam int NBTN   = (1 << NUM_BITS) - 1;
  localparam int MAX_DG = (DELAY_TIME > GAP_TIME) ? DELAY_TIME : GAP_TIME;
  localparam int MAX_T  = (MAX_DG > QUIZ_TIMEOUT) ? MAX_DG : QUIZ_TIMEOUT;
  localparam int CNT_W  = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);
  localparam int IDX_W  = (NUM_BITS > 2) ? 2 : 1;

  localparam logic [CNT_W-1:0]    DELAY_LAST = CNT_W'(DELAY_TIME - 1);
  localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(GAP_TIME - 1);
`ifdef BINARY_QUIZ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]    QUIZ_LAST  = CNT_W'(QUIZ_TIMEOUT - 1);
`endif
  localparam logic [IDX_W-1:0]    IDX_MSB    = IDX_W'(NUM_BITS - 1);
  localparam logic [3:0]          ROUND_LAST = 4'(ROUNDS - 1);
  localparam logic [NUM_BITS-1:0] TGT_ALL1   = '1;

  // Display codes
  localparam logic [3:0] V_CORRECT = 4'd10;
  localparam logic [3:0] V_ERROR   = 4'd11;
  localparam logic [3:0] V_BLANK   = 4'd12;
  localparam logic [3:0] V_QUERY   = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_BIT = 3'd1,
    S_GAP      = 3'd2,
    S_QUIZ     = 3'd3,
    S_RESULT   = 3'd4,
    S_SCORE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          value_q, value_d;
  logic [3:0]          score_q, score_d;
  logic [3:0]          round_q, round_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_dec;
  logic [NUM_BITS-1:0] target_q, target_d, new_target, answer;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         lfsr_q;
  logic                lfsr_fb;
  logic [NBTN-1:0]     btn_q, press;
  logic                any_press;

  // Taps 16,14,13,11 (bits 15,13,12,10); shifts every cycle so the target depends on press timing
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A zero target would be unanswerable, so it maps to the all-ones value
  assign new_target = (lfsr_q[NUM_BITS-1:0] == '0) ? TGT_ALL1 : lfsr_q[NUM_BITS-1:0];
  assign idx_dec    = idx_q - IDX_W'(1);

  // Rising-edge press detection; lowest-index button wins when several rise together
  always_comb begin
    press     = btn & ~btn_q;
    any_press = |press;
    answer    = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (press[i]) answer = NUM_BITS'(i + 1);
    end
  end

  // Next-state and registered display/score; the counter restarts on every state change
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    score_d  = score_q;
    round_d  = round_q;
    idx_d    = idx_q;
    target_d = target_q;
    cnt_d    = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        value_d = V_BLANK;
        cnt_d   = '0;
        if (any_press) begin
          target_d = new_target;
          idx_d    = IDX_MSB;
          round_d  = '0;
          score_d  = '0;
          state_d  = S_SHOW_BIT;
          value_d  = {3'b000, new_target[NUM_BITS-1]};
        end
      end
      S_SHOW_BIT: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = S_GAP;
          value_d = V_BLANK;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d   = idx_dec;
            state_d = S_SHOW_BIT;
            value_d = {3'b000, target_q[idx_dec]};
          end else begin
            state_d = S_QUIZ;
            value_d = V_QUERY;
          end
        end
      end
      S_QUIZ: begin
        if (any_press) begin
          state_d = S_RESULT;
          cnt_d   = '0;
          if (answer == target_q) begin
            value_d = V_CORRECT;
            score_d = (score_q == 4'd9) ? score_q : score_q + 4'd1;
          end else begin
            value_d = V_ERROR;
          end
        end
`ifdef BINARY_QUIZ_TIMEOUT_EN
        // A press in the expiry cycle is handled above and wins over the timeout
        else if (cnt_q == QUIZ_LAST) begin
          state_d = S_RESULT;
          value_d = V_ERROR;
          cnt_d   = '0;
        end
`else
        // Unbounded wait: keep the counter parked so it never wraps
        else begin
          cnt_d = '0;
        end
`endif
      end
      S_RESULT: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d = '0;
          if (round_q < ROUND_LAST) begin
            round_d  = round_q + 4'd1;
            target_d = new_target;
            idx_d    = IDX_MSB;
            state_d  = S_SHOW_BIT;
            value_d  = {3'b000, new_target[NUM_BITS-1]};
          end else begin
            state_d = S_SCORE;
            value_d = score_q;
          end
        end
      end
      S_SCORE: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = S_IDLE;
          value_d = V_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        value_d = V_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath, press history and LFSR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      value_q  <= V_BLANK;
      score_q  <= '0;
      round_q  <= '0;
      idx_q    <= IDX_MSB;
      target_q <= TGT_ALL1;
      cnt_q    <= '0;
      btn_q    <= '0;
      lfsr_q   <= SEED;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      score_q  <= score_d;
      round_q  <= round_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn;
      lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign value      = value_q;
  assign score      = score_q;
  assign dbg_target = target_q;

endmodule

// File: tb/tb_game_binary_quiz_n.sv
// Bench for game_binary_quiz_n: NUM_BITS=3, ROUNDS=2, DELAY_TIME=4, GAP_TIME=2, QUIZ_TIMEOUT=8.
// Table-driven games plus hand-written corner sequences and random games against a game-level model.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_game_binary_quiz_n;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] btn;
  logic [3:0] value;
  logic [3:0] score;
  logic [2:0] dbg_target;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    int         tgt;
    int         bi;
    logic [6:0] pat;
    int         w;
    int         exp_v;
    int         r2ok;
    int         exp_sc;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  game_binary_quiz_n #(
    .NUM_BITS(3), .ROUNDS(2), .DELAY_TIME(4), .GAP_TIME(2), .QUIZ_TIMEOUT(8), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .value(value), .score(score), .dbg_target(dbg_target)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v, fb;
    v  = int'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'((v * 2 + fb) % 65536);
  endfunction

  function automatic int tgt_of(input logic [15:0] l);
    int t;
    t = int'(l) % 8;
    return (t == 0) ? 7 : t;
  endfunction

  function automatic int answer_of(input logic [6:0] pat);
    for (int i = 0; i < 7; i++) if (pat[i]) return i + 1;
    return 0;
  endfunction

  // Free-running random source as the game sees it
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic run(input int v, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      check(nm, int'(value), v);
      @(negedge clk);
    end
  endtask

  task automatic wait_target(input int want);
    int k;
    k = 0;
    while (tgt_of(m_lfsr) != want && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("target wait within bound", (k < 300) ? 1 : 0, 1);
  endtask

  task automatic start_game(input int want, input int bi, input bit hold);
    wait_target(want);
    check("idle before start", int'(value), 12);
    btn[bi] = 1'b1;
    @(negedge clk);
    if (!hold) btn = '0;
  endtask

  task automatic show_bits(input int tgt, input string tag);
    check($sformatf("%s dbg_target", tag), int'(dbg_target), tgt);
    for (int b = 2; b >= 0; b--) begin
      run((tgt >> b) & 1, 4, $sformatf("%s bit%0d", tag, b));
      run(12, 2, $sformatf("%s gap%0d", tag, b));
    end
  endtask

  task automatic quiz_press(input logic [6:0] pat, input int w, input int exp_sc, input string tag);
    for (int i = 0; i < w; i++) begin
      check($sformatf("%s quiz wait", tag), int'(value), 13);
      @(negedge clk);
    end
    check($sformatf("%s quiz", tag), int'(value), 13);
    btn = pat;
    @(negedge clk);
    btn = '0;
    check($sformatf("%s score", tag), int'(score), exp_sc);
  endtask

  task automatic result_phase(input int exp_v, input string tag, output int nt);
    nt = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s result", tag), int'(value), exp_v);
      if (i == 3) nt = tgt_of(m_lfsr);
      @(negedge clk);
    end
  endtask

  task automatic score_phase(input int sc, input string tag);
    run(sc, 4, $sformatf("%s score display", tag));
    check($sformatf("%s back to idle", tag), int'(value), 12);
    check($sformatf("%s score kept", tag), int'(score), sc);
  endtask

  task automatic play_game(input vec_t v, input string tag);
    int nt, sc1, w2, dummy;
    logic [6:0] pat2;
    sc1 = (v.exp_v == 10) ? 1 : 0;
    start_game(v.tgt, v.bi, 1'b0);
    show_bits(v.tgt, {tag, " r1"});
    quiz_press(v.pat, v.w, sc1, {tag, " r1"});
    result_phase(v.exp_v, {tag, " r1"}, nt);
    show_bits(nt, {tag, " r2"});
    pat2 = (v.r2ok != 0) ? 7'(1 << (nt - 1)) : 7'(1 << (nt % 7));
    w2   = int'($urandom_range(7, 0));
    quiz_press(pat2, w2, sc1 + v.r2ok, {tag, " r2"});
    result_phase((v.r2ok != 0) ? 10 : 11, {tag, " r2"}, dummy);
    score_phase(v.exp_sc, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nt, dummy;
    vec_t rv;
    //             tgt bi  pat         w  exp_v r2ok exp_sc
    vecs[0] = '{5, 0, 7'b0010000, 0, 10, 1, 2};
    vecs[1] = '{5, 2, 7'b0010100, 2, 11, 1, 1};
    vecs[2] = '{7, 6, 7'b1000000, 3, 10, 0, 1};
    vecs[3] = '{1, 1, 7'b1111111, 1, 10, 0, 1};
    vecs[4] = '{3, 5, 7'b0000010, 5, 11, 0, 0};
    vecs[5] = '{6, 3, 7'b0100000, 7, 10, 1, 2};
    vecs[6] = '{4, 4, 7'b0001000, 4, 10, 1, 2};

    reset = 1'b1;
    btn   = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset value", int'(value), 12);
    check("reset score", int'(score), 0);
    check("reset target", int'(dbg_target), 7);
    reset = 1'b0;
    run(12, 3, "idle after reset");
    check("idle target", int'(dbg_target), 7);

    for (int i = 0; i < 7; i++) play_game(vecs[i], $sformatf("vec%0d", i));

    // No answer at all in either round
`ifdef BINARY_QUIZ_TIMEOUT_EN
    start_game(2, 3, 1'b0);
    show_bits(2, "tmo r1");
    run(13, 8, "tmo r1 window");
    check("tmo r1 score", int'(score), 0);
    result_phase(11, "tmo r1", nt);
    show_bits(nt, "tmo r2");
    run(13, 8, "tmo r2 window");
    result_phase(11, "tmo r2", dummy);
    score_phase(0, "tmo");
`else
    start_game(2, 3, 1'b0);
    show_bits(2, "notmo r1");
    run(13, 20, "notmo r1 unbounded wait");
    quiz_press(7'b0000010, 0, 1, "notmo r1");
    result_phase(10, "notmo r1", nt);
    show_bits(nt, "notmo r2");
    quiz_press(7'(1 << (nt % 7)), 0, 1, "notmo r2");
    result_phase(11, "notmo r2", dummy);
    score_phase(1, "notmo");
`endif

    // Button held from IDLE into QUIZ must not answer; a fresh edge does
    start_game(5, 4, 1'b1);
    show_bits(5, "hold r1");
    run(13, 5, "hold quiz held");
    btn = '0;
    quiz_press(7'b0010000, 1, 1, "hold r1");
    result_phase(10, "hold r1", nt);
    show_bits(nt, "hold r2");
    quiz_press(7'(1 << (nt - 1)), 0, 2, "hold r2");
    result_phase(10, "hold r2", dummy);
    score_phase(2, "hold");

    // Reset during round-2 GAP, then a full two-round game must follow
    start_game(5, 0, 1'b0);
    show_bits(5, "rst r1");
    quiz_press(7'b0010000, 0, 1, "rst r1");
    result_phase(10, "rst r1", nt);
    run((nt >> 2) & 1, 4, "rst r2 bit2");
    check("rst in gap", int'(value), 12);
    reset = 1'b1;
    #1;
    check("rst async value", int'(value), 12);
    check("rst async score", int'(score), 0);
    check("rst async target", int'(dbg_target), 7);
    @(negedge clk);
    reset = 1'b0;
    rv = '{3, 1, 7'b0000100, 0, 10, 1, 2};
    play_game(rv, "after rst");

    for (int g = 0; g < 15; g++) begin
      rv.tgt = int'($urandom_range(7, 1));
      rv.bi  = int'($urandom_range(6, 0));
      rv.pat = 7'($urandom_range(127, 1));
      rv.w   = int'($urandom_range(7, 0));
      rv.exp_v  = (answer_of(rv.pat) == rv.tgt) ? 10 : 11;
      rv.r2ok   = int'($urandom_range(1, 0));
      rv.exp_sc = ((rv.exp_v == 10) ? 1 : 0) + rv.r2ok;
      play_game(rv, $sformatf("rnd%0d", g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
